// File: rtl/cmac_tx_gate.sv
// Gates a user AXI-Stream toward the CMAC TX path on whole-packet boundaries and
// pulses the CMAC TX datapath reset on local faults, with a holdoff between pulses.
module cmac_tx_gate #(
   parameter int DATA_WIDTH      = 512,
   parameter int RESET_TIMEOUT   = 50,
   parameter int HOLDOFF_TIMEOUT = 644531250
) (
   input  logic                    tx_clk,
   input  logic                    sys_resetn_in,
   input  logic                    stat_rx_aligned,
   input  logic                    stat_tx_local_fault,
   input  logic [DATA_WIDTH-1:0]   axis_in_tdata,
   input  logic [DATA_WIDTH/8-1:0] axis_in_tkeep,
   input  logic                    axis_in_tlast,
   input  logic                    axis_in_tvalid,
   output logic                    axis_in_tready,
   output logic [DATA_WIDTH-1:0]   axis_out_tdata,
   output logic [DATA_WIDTH/8-1:0] axis_out_tkeep,
   output logic                    axis_out_tlast,
   output logic                    axis_out_tvalid,
   input  logic                    axis_out_tready,
   output logic                    reset_tx_datapath,
   output logic                    link_up,
   output logic [31:0]             drop_count
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] PASS      = 2'd1;
   localparam logic [1:0] DROP      = 2'd2;

   localparam logic [1:0] F_IDLE    = 2'd0;
   localparam logic [1:0] F_RESET   = 2'd1;
   localparam logic [1:0] F_HOLDOFF = 2'd2;

   localparam logic [31:0] RST_LOAD  = (RESET_TIMEOUT   == 0) ? 32'd1 : 32'(RESET_TIMEOUT);
   localparam logic [31:0] HOLD_LOAD = (HOLDOFF_TIMEOUT == 0) ? 32'd1 : 32'(HOLDOFF_TIMEOUT);

   logic [1:0]  rst_sync;
   logic        rst_n;
   logic [3:0]  aligned_sync;
   logic        sync_aligned;
   logic [1:0]  p_state;
   logic [1:0]  f_state;
   logic [31:0] f_count;
   logic        fwd;
   logic        in_hs;

   // Reset asserts immediately, releases two tx_clk edges later.
   always_ff @(posedge tx_clk or negedge sys_resetn_in) begin
      if (!sys_resetn_in) rst_sync <= '0;
      else                rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) aligned_sync <= '0;
      else        aligned_sync <= {aligned_sync[2:0], stat_rx_aligned};
   end
   assign sync_aligned = aligned_sync[3];

   assign reset_tx_datapath = (f_state == F_RESET);
   assign link_up           = sync_aligned & ~reset_tx_datapath;

   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         f_state <= F_IDLE;
         f_count <= '0;
      end else begin
         case (f_state)
            F_IDLE: begin
               if (stat_tx_local_fault) begin
                  f_state <= F_RESET;
                  f_count <= RST_LOAD;
               end
            end
            F_RESET: begin
               if (f_count <= 32'd1) begin
                  f_state <= F_HOLDOFF;
                  f_count <= HOLD_LOAD;
               end else begin
                  f_count <= f_count - 32'd1;
               end
            end
            F_HOLDOFF: begin
               if (f_count <= 32'd1) begin
                  f_state <= F_IDLE;
                  f_count <= '0;
               end else begin
                  f_count <= f_count - 32'd1;
               end
            end
            default: begin
               f_state <= F_IDLE;
               f_count <= '0;
            end
         endcase
      end
   end

   // Link state only matters in IDLE; once a packet is admitted it runs to tlast.
   always_comb begin
      fwd             = (p_state == PASS) || ((p_state == IDLE) && link_up);
      axis_out_tdata  = axis_in_tdata;
      axis_out_tkeep  = axis_in_tkeep;
      axis_out_tlast  = axis_in_tlast;
      axis_out_tvalid = rst_n & fwd & axis_in_tvalid;
      axis_in_tready  = rst_n & (fwd ? axis_out_tready : 1'b1);
   end

   assign in_hs = axis_in_tvalid & axis_in_tready;

   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state    <= IDLE;
         drop_count <= '0;
      end else if (in_hs) begin
         case (p_state)
            IDLE:    if (!axis_in_tlast) p_state <= link_up ? PASS : DROP;
            PASS:    if (axis_in_tlast)  p_state <= IDLE;
            DROP:    if (axis_in_tlast)  p_state <= IDLE;
            default: p_state <= IDLE;
         endcase
         if (axis_in_tlast && !fwd && (drop_count != '1))
            drop_count <= drop_count + 32'd1;
      end
   end

endmodule

// File: doc/cmac_tx_gate.md
CMAC_TX_GATE -- requirements
Module: cmac_tx_gate

Interface
REQ-001 Parameter DATA_WIDTH, default 512, tdata width in bits; tkeep width is DATA_WIDTH/8.
REQ-002 Parameter RESET_TIMEOUT, default 50, number of tx_clk cycles that reset_tx_datapath is asserted per fault event.
REQ-003 Parameter HOLDOFF_TIMEOUT, default 644531250, number of tx_clk cycles after a datapath reset during which stat_tx_local_fault is ignored.
REQ-004 tx_clk  in  1  sole clock; all logic is synchronous to it.
REQ-005 sys_resetn_in  in  1  asynchronous, active-low reset, deasserted synchronously internally.
REQ-006 stat_rx_aligned  in  1  CMAC PCS alignment; asynchronous to tx_clk.
REQ-007 stat_tx_local_fault  in  1  CMAC TX local fault; synchronous to tx_clk.
REQ-008 axis_in_tdata/tkeep/tlast/tvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  user packet stream.
REQ-009 axis_in_tready  out  1  ready toward user.
REQ-010 axis_out_tdata/tkeep/tlast/tvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  stream to CMAC axis_tx.
REQ-011 axis_out_tready  in  1  ready from CMAC.
REQ-012 reset_tx_datapath  out  1  drives CMAC gtwiz_reset_tx_datapath, active-high.
REQ-013 link_up  out  1  sync_aligned AND NOT reset_tx_datapath.
REQ-014 drop_count  out  32  number of packets discarded since reset.

Function
REQ-015 stat_rx_aligned is synchronized into tx_clk by a 4-flop synchronizer (sync_aligned); all decisions use sync_aligned.
REQ-016 Packet FSM states: IDLE (between packets), PASS (forwarding), DROP (discarding).
REQ-017 IDLE: on axis_in_tvalid with link_up=1, the beat is forwarded and state goes to PASS; with link_up=0, the beat is accepted and discarded and state goes to DROP.
REQ-018 A first beat with tlast=1 completes its packet in the same handshake; state remains IDLE and, if dropped, drop_count increments.
REQ-019 IDLE/PASS forwarding is zero-latency combinational: axis_out_tdata/tkeep/tlast/tvalid = axis_in_*, axis_in_tready = axis_out_tready.
REQ-020 PASS returns to IDLE on the handshake (axis_out_tvalid AND axis_out_tready) of a tlast beat.
REQ-021 PASS is never aborted by loss of link_up or by reset_tx_datapath; the packet in flight completes to tlast.
REQ-022 DROP: axis_in_tready=1, axis_out_tvalid=0; on an accepted tlast beat, drop_count increments and state returns to IDLE.
REQ-023 drop_count saturates at 0xFFFFFFFF.
REQ-024 The pass/drop decision is made only at the first beat of a packet; link_up changing mid-packet never splits a packet.
REQ-025 Fault FSM states: F_IDLE, F_RESET, F_HOLDOFF.
REQ-026 F_IDLE: stat_tx_local_fault=1 loads a down-counter with RESET_TIMEOUT and enters F_RESET.
REQ-027 F_RESET: reset_tx_datapath=1 for exactly RESET_TIMEOUT cycles, then the counter loads HOLDOFF_TIMEOUT and the FSM enters F_HOLDOFF.
REQ-028 F_HOLDOFF: stat_tx_local_fault is ignored; on counter expiry the FSM returns to F_IDLE, where a still-asserted fault re-triggers F_RESET on the next cycle.
REQ-029 Counters are 32 bits; RESET_TIMEOUT and HOLDOFF_TIMEOUT values of 0 are treated as 1.

Reset
REQ-030 While sys_resetn_in=0: packet FSM=IDLE, fault FSM=F_IDLE, counters=0, drop_count=0, reset_tx_datapath=0, synchronizer flops=0 (so link_up=0), axis_out_tvalid=0, axis_in_tready=0.
REQ-031 Reset asserted mid-packet abandons the packet; after release the next beat is treated as a first beat.

Verification
REQ-032 Aligned link, 3-beat packet, axis_out_tready=1 -> 3 beats appear on axis_out in the same cycles, drop_count=0.
REQ-033 stat_rx_aligned=0, two 4-beat packets -> axis_out_tvalid never asserts, axis_in_tready=1 throughout, drop_count=2.
REQ-034 stat_rx_aligned falls after beat 2 of a 6-beat packet -> all 6 beats forwarded; the next packet is dropped, drop_count=1.
REQ-035 stat_tx_local_fault pulsed 1 cycle, RESET_TIMEOUT=50, HOLDOFF_TIMEOUT=1000 -> reset_tx_datapath high exactly 50 cycles; a second pulse 200 cycles later causes no reset; fault held high afterward re-triggers after holdoff expiry.
REQ-036 axis_out_tready toggled randomly during PASS -> no beat duplicated or lost; output matches input order and content.
REQ-037 sys_resetn_in asserted during beat 3 of a packet -> all outputs at REQ-030 values; link_up stays 0 for at least 4 cycles after release.
